mux8_rr_sched: RTL
==================

# mux8_rr_sched

Round-robin scheduler that shares a single 8:1 multiplexer path between eight requesters. Each requester raises a level request. The block grants one requester at a time, drives the mux select for it, and bounds each tenure with a hold counter so no requester can starve the others. It sits directly in front of the existing `mux8x1` and owns its `sel` input.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles one requester may own the path (legal range 1..15).
- `N`, default 8: number of requesters. Fixed at 8; the parameter exists for documentation and must not be overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  level request per requester; bit i corresponds to `in[i]`.
- `in`  in  8  data bits presented to the mux.
- `grant`  out  8  one-hot owner of the path; all zeros when idle.
- `sel`  out  3  registered mux select; equals the index of the set `grant` bit.
- `out`  out  1  mux output `in[sel]`, combinational from the registered `sel`.
- `out_valid`  out  1  high when `out` carries data from a granted, still-requesting source.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: one owner held in `sel`.
- Priority pointer `ptr` (3 bits):
  - Search order is `ptr`, `ptr+1`, …, `ptr+7`, modulo 8.
  - The first set `req` bit in that order wins.
- IDLE:
  - If `req` != 0, load `sel` with the winner, set `grant` to the matching one-hot value, clear `cnt`, and go to BUSY.
  - Otherwise stay in IDLE with `grant`=0.
- BUSY, release condition: `req[sel]`=0, or `cnt`==`HOLD_MAX`-1.
  - With no release: `cnt` increments and `sel` holds.
  - On release: `ptr` becomes `sel`+1 (mod 8, 7 wraps to 0). Arbitration then runs immediately from that new pointer, using the current `req`.
    - Winner found: go straight to the next owner with no idle bubble and clear `cnt`. The old owner may win again if it is the only requester.
    - No winner: go to IDLE with `grant`=0.
- `out_valid` = (state==BUSY) && `req[sel]`. It is low during the cycle in which the owner drops its request.
- `cnt` is 4 bits wide and saturates. It never wraps within a tenure.
- `sel` keeps its last value while in IDLE, so `out` still follows `in[sel]`, but `out_valid`=0.

## Timing
- Reset values:
  - state=IDLE, `grant`=8'h00, `sel`=3'd0, `ptr`=3'd0, `cnt`=0, `out_valid`=0.
  - `out` = `in[0]`.
- Grant latency: `req` sampled at edge k produces `grant`/`sel` valid after edge k and usable in cycle k+1. This is one cycle.
- Tenure: at most `HOLD_MAX` cycles with `grant` held.
- Handover: the old owner's last cycle is followed directly by the new owner's first cycle, with zero gap.
- Simultaneous requests: rotation order decides; there is no fixed priority.
- A request arriving in the same cycle as a release is considered in that release's arbitration.
- `rst` asserted mid-tenure: the next edge forces all reset values, regardless of `req`.
- `req` changing on non-owners never affects `sel` until a release.

## Structure
- Shared include `mux8_defs.vh` holds:
  - state encodings `ST_IDLE`=1'b0 and `ST_BUSY`=1'b1;
  - `SEL_W`=3;
  - `REQ_N`=8.
- Sub-modules:
  - The existing `mux8x1` is instantiated unchanged for the datapath.
  - One new sub-module, `rr_pick8`, is natural: a combinational rotate-and-find-first that takes `req` and `ptr` and returns `idx` and `any`.
- Expected size: about 150 lines of RTL.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=8'hFF. Required: `grant`=0, `sel`=0, `out_valid`=0 throughout. After release, the first grant goes to index 0.
- Single requester: `req`=8'h08 held, `HOLD_MAX`=4. Required: `grant`=8'h08 for 4 cycles, then re-granted to 3 with no gap. `out` tracks `in[3]`.
- Rotation: `req`=8'h81 held. Required: grant sequence 0,7,0,7, each tenure 4 cycles, 8'h01↔8'h80 handover with zero bubble. This also exercises the wrap from 7 to 0.
- Early drop: `req`=8'h06. Requester 1 drops its request after 2 cycles of grant. Required: `out_valid`=0 in the drop cycle, then `grant`=8'h04 on the next edge.
- Idle return: a single request on 5 is dropped. Required: state IDLE, `grant`=0, `sel` stays 5, `out_valid`=0. A new request on 2 is then granted 1 cycle later.
- Mid-tenure reset: assert `rst` while 6 owns the path at `cnt`=2. Required: next cycle `grant`=0, `ptr`=0. With `req`=8'h41 afterwards, 0 wins first.

Source files
------------

// File: rtl/mux8_rr_sched_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
// State encodings, select width and requester count live here so every file agrees.
package mux8_rr_sched_pkg;

    localparam int SEL_W = 3;
    localparam int REQ_N = 8;
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Index that follows a given select, wrapping 7 back to 0.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux8_rr_sched_mux.sv
// Plain 8:1 single-bit multiplexer for the shared data path.
// The scheduler owns its select input.
module mux8x1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux8_rr_sched_pick.sv
// Combinational rotate-and-find-first over eight requests.
// The search starts at ptr and walks upward modulo 8.
module rr_pick8
    import mux8_rr_sched_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit is the last one written.
    always_comb begin
        idx  = ptr;
        any  = |req;
        cand = '0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 mux between eight level requesters.
// Each tenure is bounded by HOLD_MAX cycles; handover happens with no idle bubble.
module mux8_rr_sched
    import mux8_rr_sched_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int N        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     in,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] sel,
    output logic             out,
    output logic             out_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             release_now;

    // While busy, arbitration looks ahead from the pointer a release would install.
    assign pick_ptr    = (state_q == ST_BUSY) ? next_idx(sel_q) : ptr_q;
    assign release_now = (state_q == ST_BUSY) && (!req[sel_q] || (cnt_q == CNT_LAST));

    rr_pick8 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    ptr_d = next_idx(sel_q);
                    if (pick_any) begin
                        sel_d = pick_idx;
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        grant = '0;
        if (state_q == ST_BUSY) begin
            grant[sel_q] = 1'b1;
        end
    end

    assign sel       = sel_q;
    assign out_valid = (state_q == ST_BUSY) && req[sel_q];

    mux8x1 u_mux (
        .in  (in),
        .sel (sel_q),
        .out (out)
    );

endmodule
